mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request / memory / response bundle for mem_access_unit.
// slave: the unit's view. master: the pipeline-and-memory side.
interface mem_access_unit_if;
  // pipeline request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_op;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // data memory port
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  // response
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_op, req_sign, req_addr, req_wdata,
    input  mem_rdata, rsp_ready,
    output req_ready, mem_addr, mem_be, mem_wdata, mem_we,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_op, req_sign, req_addr, req_wdata,
    output mem_rdata, rsp_ready,
    input  req_ready, mem_addr, mem_be, mem_wdata, mem_we,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one outstanding request, IDLE -> ACCESS -> RESP.
// Errored requests (misaligned, out of range, illegal op) skip ACCESS.
module mem_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_unit_if.slave     bus,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [1:0]  r_op;
  logic        r_sign;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_err_cnt;

  logic        w_req_err;
  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_load_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_accept = (r_state == IDLE) && bus.req_valid;
  assign err_cnt  = r_err_cnt;

  // Classify the incoming request as errored
  always_comb begin
    w_req_err = 1'b0;
    case (bus.req_op)
      2'b00:   if (bus.req_addr[1:0] != 2'b00) w_req_err = 1'b1;
      2'b10:   if (bus.req_addr[0]) w_req_err = 1'b1;
      2'b11:   w_req_err = 1'b1;
      default: ;
    endcase
    if (bus.req_addr >= ADDR_LIMIT) w_req_err = 1'b1;
  end

  // Byte enables and lane-replicated store data from the registered request
  always_comb begin
    w_be         = '0;
    w_lane_wdata = r_wdata;
    case (r_op)
      2'b00: w_be = 4'b1111;
      2'b01: begin
        w_be         = 4'b0001 << r_addr[1:0];
        w_lane_wdata = {4{r_wdata[7:0]}};
      end
      2'b10: begin
        w_be         = r_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Select the addressed lane of the read word and extend it
  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      2'd3:    w_byte = bus.mem_rdata[31:24];
      default: ;
    endcase
    w_half      = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    w_load_data = bus.mem_rdata;
    case (r_op)
      2'b01:   w_load_data = {{24{r_sign & w_byte[7]}}, w_byte};
      2'b10:   w_load_data = {{16{r_sign & w_half[15]}}, w_half};
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_next = w_req_err ? RESP : ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, load data capture and saturating error counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_op      <= '0;
      r_sign    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_op    <= bus.req_op;
        r_sign  <= bus.req_sign;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_err   <= w_req_err;
        r_rdata <= '0;
        if (w_req_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (r_state == ACCESS) r_rdata <= r_we ? '0 : w_load_data;
    end
  end

  // Outputs: memory port is live only during ACCESS
  always_comb begin
    bus.req_ready = (r_state == IDLE);
    bus.rsp_valid = (r_state == RESP);
    bus.rsp_rdata = r_rdata;
    bus.rsp_err   = r_err;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (r_state == ACCESS) begin
      bus.mem_addr  = {r_addr[31:2], 2'b00};
      bus.mem_be    = w_be;
      bus.mem_wdata = w_lane_wdata;
      bus.mem_we    = r_we;
    end
  end

endmodule
